// File: rtl/jtframe_lfbuf_ddr_nbuf.sv
// Line-frame-buffer DDR controller: streams finished game lines into DDR frame
// slots and fetches display lines back into the screen line buffer during H blank.
module jtframe_lfbuf_ddr_nbuf #(
  parameter int         VW    = 8,
  parameter int         HW    = 9,
  parameter int         BURST = 64,
  parameter int         NBUF  = 2,
  parameter logic [3:0] BASE  = 4'd3
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          lhbl,
  input  logic          lvbl,
  input  logic          ln_done,
  input  logic [VW-1:0] ln_v,
  input  logic [VW-1:0] vrender,
  input  logic          vs,
  output logic [HW-2:0] fb_addr,
  input  logic [31:0]   fb_din,
  output logic          fb_clr,
  output logic          fb_done,
  output logic          line,
  output logic [31:0]   fb_dout,
  output logic [HW-2:0] rd_addr,
  output logic          scr_we,
  output logic          ddram_clk,
  input  logic          ddram_busy,
  output logic [7:0]    ddram_burstcnt,
  output logic [28:0]   ddram_addr,
  output logic          ddram_rd,
  output logic          ddram_we,
  output logic [63:0]   ddram_din,
  output logic [7:0]    ddram_be,
  input  logic [63:0]   ddram_dout,
  input  logic          ddram_dout_ready,
  output logic [1:0]    wr_idx,
  output logic [1:0]    rd_idx,
  output logic [7:0]    overrun
);
  localparam int AW = HW - 1;
  localparam int BW = $clog2(BURST);
  localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};
  localparam logic [BW-1:0] LAST_BEAT = {BW{1'b1}};

  if (6 + VW + HW - 1 > 29) begin : g_addr_chk
    $error("jtframe_lfbuf_ddr_nbuf: slot/line/word fields do not fit in ddram_addr");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} st_t;

  st_t           st_q, st_d;
  logic          lhbl_dly_q, lvbl_dly_q, ln_done_dly_q, vs_dly_q;
  logic          do_wr_q, do_wr_d, do_rd_q, do_rd_d;
  logic [VW-1:0] pend_v_q, pend_v_d;
  logic [7:0]    overrun_q, overrun_d;
  logic [1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, last_done_q, last_done_d;
  logic [1:0]    nxt_slot_s;
  logic [AW-1:0] fb_addr_q, fb_addr_d, rd_addr_q, rd_addr_d, rd_cnt_q, rd_cnt_d;
  logic          fb_clr_q, fb_clr_d, fb_done_q, fb_done_d, line_q, line_d;
  logic [31:0]   fb_dout_q, fb_dout_d;
  logic          scr_we_q, scr_we_d;
  logic [28:0]   ddram_addr_q, ddram_addr_d;
  logic          ddram_rd_q, ddram_rd_d, ddram_we_q, ddram_we_d;
  logic          wr_start_s, rd_start_s;
  logic          ln_rise_s, hb_fall_s, vb_fall_s, vs_rise_s;
  logic          unused_dout_s;

  // Base word address of a line: BASE on top, then slot, line index, word 0.
  function automatic logic [28:0] line_addr(input logic [1:0] slot, input logic [VW-1:0] v);
    logic [28:0] a;
    a              = 29'd0;
    a[28:25]       = BASE;
    a[AW+VW +: 2]  = slot;
    a[AW +: VW]    = v;
    return a;
  endfunction

  assign ln_rise_s     = ln_done & ~ln_done_dly_q;
  assign hb_fall_s     = ~lhbl & lhbl_dly_q;
  assign vb_fall_s     = ~lvbl & lvbl_dly_q;
  assign vs_rise_s     = vs & ~vs_dly_q;
  assign unused_dout_s = ^ddram_dout[63:32];

  // Next write slot: the lowest slot held by neither the writer nor the display.
  always_comb begin
    nxt_slot_s = wr_idx_q;
    if (NBUF == 2) begin
      nxt_slot_s = {1'b0, ~wr_idx_q[0]};
    end else begin
      for (int i = NBUF - 1; i >= 0; i--) begin
        if (2'(i) != wr_idx_q && 2'(i) != rd_idx_q) nxt_slot_s = 2'(i);
        else nxt_slot_s = nxt_slot_s;
      end
    end
  end

  // Next-state logic: FSM, event latches, slot rotation and line-buffer clear.
  always_comb begin
    st_d         = st_q;
    pend_v_d     = ln_rise_s ? ln_v : pend_v_q;
    overrun_d    = overrun_q;
    wr_idx_d     = vs_rise_s ? nxt_slot_s : wr_idx_q;
    last_done_d  = vs_rise_s ? wr_idx_q : last_done_q;
    rd_idx_d     = vb_fall_s ? last_done_q : rd_idx_q;
    fb_addr_d    = fb_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_cnt_d     = rd_cnt_q;
    fb_clr_d     = fb_clr_q;
    fb_done_d    = 1'b0;
    line_d       = line_q;
    fb_dout_d    = fb_dout_q;
    scr_we_d     = 1'b0;
    ddram_addr_d = ddram_addr_q;
    ddram_rd_d   = ddram_rd_q;
    ddram_we_d   = ddram_we_q;
    wr_start_s   = 1'b0;
    rd_start_s   = 1'b0;

    case (st_q)
      IDLE: begin
        if (do_rd_q) begin
          rd_start_s   = 1'b1;
          ddram_addr_d = line_addr(rd_idx_q, vrender);
          ddram_rd_d   = 1'b1;
          rd_cnt_d     = '0;
          st_d         = READ;
        end else if (do_wr_q && !fb_clr_q) begin
          wr_start_s   = 1'b1;
          ddram_addr_d = line_addr(wr_idx_q, pend_v_q);
          fb_addr_d    = '0;
          ddram_we_d   = 1'b1;
          line_d       = ~line_q;
          fb_done_d    = 1'b1;
          st_d         = WRITE;
        end else begin
          st_d = IDLE;
        end
      end
      READ: begin
        if (ddram_rd_q && !ddram_busy) ddram_rd_d = 1'b0;
        else ddram_rd_d = ddram_rd_q;
        // A beat cannot belong to a request that has not been accepted yet.
        if (ddram_dout_ready && !ddram_rd_q) begin
          fb_dout_d = ddram_dout[31:0];
          rd_addr_d = rd_cnt_q;
          scr_we_d  = 1'b1;
          rd_cnt_d  = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_WORD) begin
            st_d = IDLE;
          end else if (rd_cnt_q[BW-1:0] == LAST_BEAT) begin
            ddram_addr_d = ddram_addr_q + 29'(BURST);
            ddram_rd_d   = 1'b1;
          end else begin
            st_d = READ;
          end
        end else begin
          st_d = READ;
        end
      end
      WRITE: begin
        if (!ddram_busy) begin
          fb_addr_d = fb_addr_q + 1'b1;
          if (fb_addr_q == LAST_WORD) begin
            ddram_we_d = 1'b0;
            fb_clr_d   = 1'b1;
            st_d       = IDLE;
          end else if (fb_addr_q[BW-1:0] == LAST_BEAT) begin
            ddram_addr_d = ddram_addr_q + 29'(BURST);
          end else begin
            st_d = WRITE;
          end
        end else begin
          st_d = WRITE;
        end
      end
      default: begin
        st_d       = IDLE;
        ddram_rd_d = 1'b0;
        ddram_we_d = 1'b0;
      end
    endcase

    // The clear sweep runs on its own; only reads may overlap it.
    if (fb_clr_q) begin
      fb_addr_d = fb_addr_q + 1'b1;
      fb_clr_d  = (fb_addr_q != LAST_WORD);
    end else begin
      fb_clr_d = fb_clr_d;
    end

    do_rd_d = (do_rd_q & ~rd_start_s) | (hb_fall_s & lvbl);
    do_wr_d = (do_wr_q & ~wr_start_s) | ln_rise_s;
    if (ln_rise_s && do_wr_q && !wr_start_s && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    else overrun_d = overrun_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= IDLE;
      lhbl_dly_q    <= 1'b0;
      lvbl_dly_q    <= 1'b0;
      ln_done_dly_q <= 1'b0;
      vs_dly_q      <= 1'b0;
      do_wr_q       <= 1'b0;
      do_rd_q       <= 1'b0;
      pend_v_q      <= '0;
      overrun_q     <= 8'd0;
      wr_idx_q      <= 2'd0;
      rd_idx_q      <= 2'(NBUF - 1);
      last_done_q   <= 2'(NBUF - 1);
      fb_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_cnt_q      <= '0;
      fb_clr_q      <= 1'b0;
      fb_done_q     <= 1'b0;
      line_q        <= 1'b0;
      fb_dout_q     <= 32'd0;
      scr_we_q      <= 1'b0;
      ddram_addr_q  <= 29'd0;
      ddram_rd_q    <= 1'b0;
      ddram_we_q    <= 1'b0;
    end else begin
      st_q          <= st_d;
      lhbl_dly_q    <= lhbl;
      lvbl_dly_q    <= lvbl;
      ln_done_dly_q <= ln_done;
      vs_dly_q      <= vs;
      do_wr_q       <= do_wr_d;
      do_rd_q       <= do_rd_d;
      pend_v_q      <= pend_v_d;
      overrun_q     <= overrun_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      last_done_q   <= last_done_d;
      fb_addr_q     <= fb_addr_d;
      rd_addr_q     <= rd_addr_d;
      rd_cnt_q      <= rd_cnt_d;
      fb_clr_q      <= fb_clr_d;
      fb_done_q     <= fb_done_d;
      line_q        <= line_d;
      fb_dout_q     <= fb_dout_d;
      scr_we_q      <= scr_we_d;
      ddram_addr_q  <= ddram_addr_d;
      ddram_rd_q    <= ddram_rd_d;
      ddram_we_q    <= ddram_we_d;
    end
  end

  assign fb_addr        = fb_addr_q;
  assign fb_clr         = fb_clr_q;
  assign fb_done        = fb_done_q;
  assign line           = line_q;
  assign fb_dout        = fb_dout_q;
  assign rd_addr        = rd_addr_q;
  assign scr_we         = scr_we_q;
  assign ddram_clk      = clk;
  assign ddram_burstcnt = 8'(BURST);
  assign ddram_addr     = ddram_addr_q;
  assign ddram_rd       = ddram_rd_q;
  assign ddram_we       = ddram_we_q;
  assign ddram_din      = {32'd0, fb_din};
  assign ddram_be       = 8'h0F;
  assign wr_idx         = wr_idx_q;
  assign rd_idx         = rd_idx_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_jtframe_lfbuf_ddr_nbuf.sv
// Directed bench for jtframe_lfbuf_ddr_nbuf with a DDR/line-buffer model and
// write/read scoreboards; a second NBUF=3 instance covers triple buffering.
module tb_jtframe_lfbuf_ddr_nbuf;
  typedef struct { logic [28:0] a; logic [31:0] d; } wexp_t;
  typedef struct { logic [7:0] a; logic [31:0] d; } rexp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic lhbl, lvbl, ln_done, vs;
  logic [7:0] ln_v, vrender;
  logic [31:0] fb_din, fb_din3;
  logic ddram_busy = 1'b0, ddram_dout_ready = 1'b0;
  logic [63:0] ddram_dout = 64'd0;

  logic [7:0] fb_addr, rd_addr, overrun, ddram_burstcnt, ddram_be;
  logic fb_clr, fb_done, line, scr_we, ddram_clk, ddram_rd, ddram_we;
  logic [31:0] fb_dout;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [1:0] wr_idx, rd_idx;

  logic [7:0] fb_addr3, rd_addr3, overrun3, burstcnt3, be3;
  logic fb_clr3, fb_done3, line3, scr_we3, ddram_clk3, ddram_rd3, ddram_we3;
  logic [31:0] fb_dout3;
  logic [28:0] ddram_addr3;
  logic [63:0] ddram_din3;
  logic [1:0] wr_idx3, rd_idx3;

  int errors = 0, checks = 0;
  int n_done = 0, n_clr = 0, n_wb = 0, n_rdacc = 0, n_scr = 0;
  logic busy_force = 1'b0, rnd_en = 1'b0;
  logic [28:0] wbeat = 29'd0, raddr = 29'd0, rbeat_i = 29'd0;
  int rbeats = 0;
  wexp_t wq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;

  // Game line buffer contents: word index plus the half currently selected.
  assign fb_din  = {7'd0, line, 8'hC3, 8'h00, fb_addr};
  assign fb_din3 = 32'd0;

  jtframe_lfbuf_ddr_nbuf #(.VW(8), .HW(9), .BURST(64), .NBUF(2), .BASE(4'd3)) dut (
    .clk(clk), .rst(rst), .lhbl(lhbl), .lvbl(lvbl), .ln_done(ln_done), .ln_v(ln_v),
    .vrender(vrender), .vs(vs), .fb_addr(fb_addr), .fb_din(fb_din), .fb_clr(fb_clr),
    .fb_done(fb_done), .line(line), .fb_dout(fb_dout), .rd_addr(rd_addr), .scr_we(scr_we),
    .ddram_clk(ddram_clk), .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt),
    .ddram_addr(ddram_addr), .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_din(ddram_din),
    .ddram_be(ddram_be), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .overrun(overrun));

  jtframe_lfbuf_ddr_nbuf #(.VW(8), .HW(9), .BURST(64), .NBUF(3), .BASE(4'd3)) dut3 (
    .clk(clk), .rst(rst), .lhbl(lhbl), .lvbl(lvbl), .ln_done(ln_done), .ln_v(ln_v),
    .vrender(vrender), .vs(vs), .fb_addr(fb_addr3), .fb_din(fb_din3), .fb_clr(fb_clr3),
    .fb_done(fb_done3), .line(line3), .fb_dout(fb_dout3), .rd_addr(rd_addr3), .scr_we(scr_we3),
    .ddram_clk(ddram_clk3), .ddram_busy(ddram_busy), .ddram_burstcnt(burstcnt3),
    .ddram_addr(ddram_addr3), .ddram_rd(ddram_rd3), .ddram_we(ddram_we3), .ddram_din(ddram_din3),
    .ddram_be(be3), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .wr_idx(wr_idx3), .rd_idx(rd_idx3), .overrun(overrun3));

  function automatic logic [28:0] mk(input logic [1:0] slot, input logic [7:0] v, input logic [7:0] w);
    return {4'd3, 7'd0, slot, v, w};
  endfunction

  function automatic logic [31:0] ddat(input logic [28:0] a);
    return {3'b101, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_write(input logic [1:0] slot, input logic [7:0] v, input logic ln);
    for (int i = 0; i < 256; i++) wq.push_back('{a: mk(slot, v, 8'(i)), d: {7'd0, ln, 8'hC3, 8'h00, 8'(i)}});
  endtask

  task automatic exp_read(input logic [1:0] slot, input logic [7:0] v);
    for (int i = 0; i < 256; i++) rq.push_back('{a: 8'(i), d: ddat(mk(slot, v, 8'(i)))});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0 || fb_clr || ddram_we || ddram_rd || rbeats != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 5000), 64'd1);
    tick(2);
  endtask

  // DDR model: busy generation, write sink, burst read responder and screen monitor.
  initial begin
    wexp_t we_e;
    rexp_t re_e;
    forever begin
      @(negedge clk);
      ddram_busy = rnd_en ? ($urandom_range(0, 3) == 0) : busy_force;
      if (fb_done) n_done++;
      if (fb_clr) n_clr++;
      if (ddram_we && !ddram_busy) begin
        n_wb++;
        if (wq.size() == 0) chk("wr_extra_beat", 64'(wq.size()), 64'd1);
        else begin
          we_e = wq.pop_front();
          chk("wr_addr", 64'(ddram_addr + wbeat), 64'(we_e.a));
          chk("wr_data", ddram_din, {32'd0, we_e.d});
        end
        wbeat = (wbeat + 29'd1) & 29'd63;
      end
      if (scr_we) begin
        n_scr++;
        if (rq.size() == 0) chk("rd_extra_beat", 64'(rq.size()), 64'd1);
        else begin
          re_e = rq.pop_front();
          chk("rd_addr", 64'(rd_addr), 64'(re_e.a));
          chk("rd_data", 64'(fb_dout), 64'(re_e.d));
        end
      end
      if (rbeats > 0) begin
        ddram_dout_ready = 1'b1;
        ddram_dout = {32'hFFFF_FFFF, ddat(raddr + rbeat_i)};
        rbeat_i = rbeat_i + 29'd1;
        rbeats--;
      end else begin
        ddram_dout_ready = 1'b0;
        ddram_dout = {32'hFFFF_FFFF, 32'hDEAD_BEEF};
      end
      if (ddram_rd && !ddram_busy) begin
        n_rdacc++;
        raddr = ddram_addr;
        rbeat_i = 29'd0;
        rbeats = 64;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [1:0] wr2_t [4];
    logic [1:0] rd2_t [4];
    logic [1:0] wr3_t [4];
    logic [1:0] rd3_t [4];
    wr2_t = '{2'd1, 2'd0, 2'd1, 2'd0};
    rd2_t = '{2'd0, 2'd1, 2'd0, 2'd1};
    wr3_t = '{2'd1, 2'd2, 2'd0, 2'd1};
    rd3_t = '{2'd0, 2'd1, 2'd2, 2'd0};
    lhbl = 1'b1; lvbl = 1'b0; ln_done = 1'b0; vs = 1'b0; ln_v = 8'd0; vrender = 8'd0;

    // Reset values
    tick(3); rst = 1'b0; tick(2);
    chk("rst_we", 64'(ddram_we), 64'd0);
    chk("rst_rd", 64'(ddram_rd), 64'd0);
    chk("rst_fb_done", 64'(fb_done), 64'd0);
    chk("rst_fb_clr", 64'(fb_clr), 64'd0);
    chk("rst_line", 64'(line), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("rst_rd_idx", 64'(rd_idx), 64'd1);
    chk("rst_rd_idx3", 64'(rd_idx3), 64'd2);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_addr", 64'(ddram_addr), 64'd0);
    chk("burstcnt", 64'(ddram_burstcnt), 64'd64);
    chk("be", 64'(ddram_be), 64'h0F);

    // Line write in V blank, slot 0, v=5
    exp_write(2'd0, 8'd5, 1'b1);
    ln_v = 8'd5; ln_done = 1'b1; tick(2); ln_done = 1'b0;
    drain("wr1_timeout");
    chk("wr1_done_cnt", 64'(n_done), 64'd1);
    chk("wr1_beats", 64'(n_wb), 64'd256);
    chk("wr1_clr_len", 64'(n_clr), 64'd256);
    chk("wr1_line", 64'(line), 64'd1);

    // Line read during H blank, slot 1, vrender=7
    lvbl = 1'b1; tick(2);
    vrender = 8'd7; exp_read(2'd1, 8'd7);
    lhbl = 1'b0; tick(2); lhbl = 1'b1;
    drain("rd1_timeout");
    chk("rd1_bursts", 64'(n_rdacc), 64'd4);
    chk("rd1_strobes", 64'(n_scr), 64'd256);

    // Overrun: stalled write, then two pending lines; only the newer is written
    busy_force = 1'b1;
    exp_write(2'd0, 8'd20, 1'b0);
    ln_v = 8'd20; ln_done = 1'b1; tick(2); ln_done = 1'b0; tick(4);
    chk("ovr_wr_busy", 64'(ddram_we), 64'd1);
    ln_v = 8'd21; ln_done = 1'b1; tick(2); ln_done = 1'b0; tick(2);
    chk("ovr_none_yet", 64'(overrun), 64'd0);
    ln_v = 8'd22; ln_done = 1'b1; tick(2); ln_done = 1'b0; tick(2);
    chk("ovr_count", 64'(overrun), 64'd1);
    exp_write(2'd0, 8'd22, 1'b1);
    busy_force = 1'b0;
    drain("ovr_timeout");
    chk("ovr_done_cnt", 64'(n_done), 64'd3);
    chk("ovr_beats", 64'(n_wb), 64'd768);

    // Simultaneous read and write request under random busy: read goes first
    rnd_en = 1'b1;
    vrender = 8'd9; exp_read(2'd1, 8'd9);
    exp_write(2'd0, 8'd30, 1'b0);
    ln_v = 8'd30; ln_done = 1'b1; lhbl = 1'b0;
    tick(1); ln_done = 1'b0; lhbl = 1'b1;
    n = 0;
    while (!fb_done && n < 5000) begin @(negedge clk); n++; end
    chk("sim_wr_start", 64'(n < 5000), 64'd1);
    chk("sim_rd_first", 64'(rq.size()), 64'd0);
    drain("sim_timeout");
    rnd_en = 1'b0; busy_force = 1'b0;
    chk("sim_bursts", 64'(n_rdacc), 64'd8);
    chk("sim_beats", 64'(n_wb), 64'd1024);

    // Asynchronous reset in the middle of a stalled write
    tick(2);
    busy_force = 1'b1;
    ln_v = 8'd40; ln_done = 1'b1; tick(2); ln_done = 1'b0;
    n = 0;
    while (!ddram_we && n < 20) begin @(negedge clk); n++; end
    chk("rst_wr_started", 64'(ddram_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 64'(ddram_we), 64'd0);
    chk("arst_line", 64'(line), 64'd0);
    chk("arst_overrun", 64'(overrun), 64'd0);
    chk("arst_addr", 64'(ddram_addr), 64'd0);
    chk("arst_rd_idx", 64'(rd_idx), 64'd1);
    @(negedge clk); tick(2);
    rst = 1'b0; busy_force = 1'b0;
    tick(600);
    chk("arst_no_done", 64'(n_done), 64'd5);
    chk("arst_no_beats", 64'(n_wb), 64'd1024);
    chk("arst_we_idle", 64'(ddram_we), 64'd0);

    // Slot rotation over four frames, double and triple buffering
    for (int k = 0; k < 4; k++) begin
      vs = 1'b1; tick(2); vs = 1'b0; tick(2);
      lvbl = 1'b0; tick(2); lvbl = 1'b1; tick(2);
      chk("rot2_wr", 64'(wr_idx), 64'(wr2_t[k]));
      chk("rot2_rd", 64'(rd_idx), 64'(rd2_t[k]));
      chk("rot3_wr", 64'(wr_idx3), 64'(wr3_t[k]));
      chk("rot3_rd", 64'(rd_idx3), 64'(rd3_t[k]));
      chk("rot3_distinct", 64'(wr_idx3 != rd_idx3), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
